// File: rtl/lfsr_cipher_pkg.sv
// lfsr_cipher_pkg: shared state encoding, config layout and LFSR helper
// for the padded-LFSR stream cipher engine.
package lfsr_cipher_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_ENC,
    S_ENC_WR,
    S_SKIP,
    S_DEC_RD,
    S_DEC_WR,
    S_FILL,
    S_DONE
  } state_t;

  localparam int OFF_PRELEN = 0;
  localparam int OFF_TAPS   = 1;
  localparam int OFF_SEED   = 2;

  localparam logic [LFSR_W-1:0] MAX_TAPS [8] = '{
    8'he1, 8'hd4, 8'hc6, 8'hb8,
    8'hb4, 8'hb2, 8'hfa, 8'hf3
  };

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s,
    input logic [LFSR_W-1:0] taps
  );
    return {s[LFSR_W-2:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR state register with seed load and
// single-step advance under an externally supplied tap mask.
module lfsr_core
  import lfsr_cipher_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] taps,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state, taps);
    end
  end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// lfsr_stream_cipher: padded-LFSR message cipher running on data memory.
// Owns the memory port while busy; encrypt builds a frame, decrypt restores it.
module lfsr_stream_cipher
  import lfsr_cipher_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            MSG_LEN   = 41,
  parameter int            FRAME_LEN = 64,
  parameter int            AW        = 8,
  parameter int            SRC_BASE  = 0,
  parameter int            CFG_BASE  = 41,
  parameter int            DST_BASE  = 64,
  parameter logic [DW-1:0] PAD_CHAR  = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic          strip,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] SRC = AW'(SRC_BASE);
  localparam logic [AW-1:0] CFG = AW'(CFG_BASE);
  localparam logic [AW-1:0] DST = AW'(DST_BASE);
  localparam logic [AW-1:0] MSG_LAST = AW'(MSG_LEN - 1);
  localparam logic [AW-1:0] FRAME_LAST = AW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] CFG_LAST = AW'(OFF_SEED + 1);
  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] wp;
  logic [DW-1:0] pre_len;
  logic [DW-1:0] taps;
  logic [DW-1:0] lfsr;
  logic [DW-1:0] plain;
  logic          run_mode;
  logic          run_strip;
  logic          seen;

  logic accept;
  logic load;
  logic step;
  logic cnt_inc;
  logic cnt_clr;
  logic wp_inc;
  logic seen_set;
  logic is_pad;
  logic drop;
  logic bad;

  lfsr_core u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .seed  (mem_rdata),
    .taps  (taps),
    .state (lfsr)
  );

  assign busy = !(state inside {S_IDLE, S_DONE});
  assign done = (state == S_DONE);

  always_comb begin
    nxt       = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    accept    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    wp_inc    = 1'b0;
    seen_set  = 1'b0;
    plain     = mem_rdata ^ lfsr;
    is_pad    = (int'(cnt) < int'(pre_len)) ||
                (int'(cnt) >= int'(pre_len) + MSG_LEN);
    drop      = run_strip && !seen && (plain == PAD_CHAR);
    bad       = (mem_rdata == '0) ||
                (int'(pre_len) + MSG_LEN > FRAME_LEN);
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          nxt     = S_CFG;
        end
      end
      S_CFG: begin
        cnt_inc = 1'b1;
        if (cnt < CFG_LAST) begin
          mem_addr = CFG + cnt;
        end else begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          if (bad) begin
            nxt = S_DONE;
          end else if (!run_mode) begin
            nxt = S_ENC;
          end else if (pre_len == '0) begin
            nxt = S_DEC_RD;
          end else begin
            nxt = S_SKIP;
          end
        end
      end
      S_ENC: begin
        if (is_pad) begin
          mem_we    = 1'b1;
          mem_addr  = DST + cnt;
          mem_wdata = PAD_CHAR ^ lfsr;
          step      = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt == FRAME_LAST) nxt = S_DONE;
        end else begin
          mem_addr = SRC + cnt - AW'(pre_len);
          nxt      = S_ENC_WR;
        end
      end
      S_ENC_WR: begin
        mem_we    = 1'b1;
        mem_addr  = DST + cnt;
        mem_wdata = plain;
        step      = 1'b1;
        cnt_inc   = 1'b1;
        nxt       = (cnt == FRAME_LAST) ? S_DONE : S_ENC;
      end
      S_SKIP: begin
        step    = 1'b1;
        cnt_inc = 1'b1;
        if (cnt == AW'(pre_len) - ONE) begin
          cnt_clr = 1'b1;
          nxt     = S_DEC_RD;
        end
      end
      S_DEC_RD: begin
        mem_addr = DST + AW'(pre_len) + cnt;
        nxt      = S_DEC_WR;
      end
      S_DEC_WR: begin
        step     = 1'b1;
        cnt_inc  = 1'b1;
        seen_set = (plain != PAD_CHAR);
        if (!drop) begin
          mem_we    = 1'b1;
          mem_addr  = SRC + wp;
          mem_wdata = plain;
          wp_inc    = 1'b1;
        end
        // Fill is needed unless this write lands on the last slot.
        if (cnt == MSG_LAST) begin
          if (run_strip && (drop || wp != MSG_LAST)) nxt = S_FILL;
          else nxt = S_DONE;
        end else begin
          nxt = S_DEC_RD;
        end
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = SRC + wp;
        mem_wdata = PAD_CHAR;
        wp_inc    = 1'b1;
        if (wp == MSG_LAST) nxt = S_DONE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wp        <= '0;
      pre_len   <= '0;
      taps      <= '0;
      run_mode  <= 1'b0;
      run_strip <= 1'b0;
      seen      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + ONE;
      if (accept) begin
        wp        <= '0;
        seen      <= 1'b0;
        err       <= 1'b0;
        run_mode  <= mode;
        run_strip <= strip;
      end else begin
        if (wp_inc) wp <= wp + ONE;
        if (seen_set) seen <= 1'b1;
      end
      if (state == S_CFG) begin
        if (cnt == AW'(OFF_PRELEN + 1)) pre_len <= mem_rdata;
        if (cnt == AW'(OFF_TAPS + 1)) taps <= mem_rdata;
        if (cnt == CFG_LAST) err <= bad;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// tb_lfsr_stream_cipher: scoreboard bench for the LFSR stream cipher;
// expected memory writes are queued at stimulus time and popped by a monitor.
module tb_lfsr_stream_cipher;

  localparam int MSG_LEN = 41;
  localparam int FRAME_LEN = 64;
  localparam int SRC = 0;
  localparam int CFG = 41;
  localparam int DST = 64;
  localparam logic [7:0] PAD = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       strip = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] orig [MSG_LEN];
  logic [7:0] exp_frame [FRAME_LEN];
  logic [7:0] taps_list [8] = '{
    8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3
  };

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t sb [$];
  int checks = 0;
  int fails = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  lfsr_stream_cipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .strip     (strip),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_t e;
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write got %h:%h want none",
                 mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (e.a !== mem_addr || e.d !== mem_wdata) begin
          fails++;
          $display("FAIL write got %h:%h want %h:%h",
                   mem_addr, mem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] nx(input logic [7:0] s,
                                    input logic [7:0] t);
    logic fb = 1'b0;
    for (int b = 0; b < 8; b++) if (t[b]) fb ^= s[b];
    return {s[6:0], fb};
  endfunction

  task automatic set_cfg(input logic [7:0] p, input logic [7:0] t,
                         input logic [7:0] s);
    mem[CFG] = p;
    mem[CFG+1] = t;
    mem[CFG+2] = s;
  endtask

  task automatic load_orig();
    for (int i = 0; i < MSG_LEN; i++) mem[SRC+i] = orig[i];
  endtask

  task automatic set_orig(input string s);
    for (int i = 0; i < MSG_LEN; i++) orig[i] = s[i];
  endtask

  task automatic fill_region(input int base, input int n,
                             input logic [7:0] v);
    for (int i = 0; i < n; i++) mem[base+i] = v;
  endtask

  task automatic push_enc();
    logic [7:0] s = mem[CFG+2];
    logic [7:0] t = mem[CFG+1];
    int p = int'(mem[CFG]);
    for (int i = 0; i < FRAME_LEN; i++) begin
      logic [7:0] b;
      b = (i < p || i >= p + MSG_LEN) ? PAD : orig[i-p];
      exp_frame[i] = b ^ s;
      sb.push_back({8'(DST + i), b ^ s});
      s = nx(s, t);
    end
  endtask

  task automatic push_dec(input logic st);
    logic [7:0] s = mem[CFG+2];
    logic [7:0] t = mem[CFG+1];
    int p = int'(mem[CFG]);
    int wp = 0;
    logic seen = 1'b0;
    for (int i = 0; i < p; i++) s = nx(s, t);
    for (int k = 0; k < MSG_LEN; k++) begin
      logic [7:0] b;
      b = mem[DST+p+k] ^ s;
      s = nx(s, t);
      if (!(st && !seen && b == PAD)) begin
        sb.push_back({8'(SRC + wp), b});
        wp++;
      end
      if (b != PAD) seen = 1'b1;
    end
    if (st) begin
      while (wp < MSG_LEN) begin
        sb.push_back({8'(SRC + wp), PAD});
        wp++;
      end
    end
  endtask

  task automatic run(input logic m, input logic st, input int exp_cyc,
                     input logic exp_err, input string tag,
                     input int glitch_at);
    int cyc = 0;
    int n = 0;
    wr_count = 0;
    @(negedge clk);
    mode = m;
    strip = st;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~m;
    strip = ~st;
    while (!done && n < 2000) begin
      if (busy) cyc++;
      start = (n == glitch_at);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_cycles"}, cyc, exp_cyc);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    for (int i = 0; i < FRAME_LEN; i++)
      if (mem[DST+i] !== exp_frame[i]) bad++;
    check({tag, "_frame_mismatches"}, bad, 0);
  endtask

  initial begin
    string ajok = "Ajok";
    int n;
    int we_seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    set_orig("Mr. Watson, come here. I want to see you.");
    load_orig();
    set_cfg(8'd9, 8'hd4, 8'h41);
    push_enc();
    run(1'b0, 1'b0, 109, 1'b0, "enc1", -1);
    check("dst64", mem[64], 8'h61);
    check("dst65", mem[65], 8'ha3);
    check_frame("enc1");

    fill_region(SRC, MSG_LEN, 8'hff);
    push_dec(1'b0);
    run(1'b1, 1'b0, 4 + 9 + 82, 1'b0, "dec1", -1);
    begin
      int bad = 0;
      for (int i = 0; i < MSG_LEN; i++)
        if (mem[SRC+i] !== orig[i]) bad++;
      check("dec1_restored_mismatches", bad, 0);
    end

    for (int i = 0; i < MSG_LEN; i++)
      orig[i] = (i >= 27 && i < 31) ? ajok[i-27] : PAD;
    load_orig();
    set_cfg(8'd10, 8'hfa, 8'h5a);
    push_enc();
    run(1'b0, 1'b0, 109, 1'b0, "enc3", -1);
    fill_region(SRC, MSG_LEN, 8'hff);
    push_dec(1'b1);
    run(1'b1, 1'b1, 4 + 10 + 82 + 27, 1'b0, "strip", -1);
    check("strip_writes", wr_count, 14 + 27);
    check("strip_word", {mem[0], mem[1], mem[2], mem[3]}, 32'h416a6f6b);
    begin
      int bad = 0;
      for (int i = 4; i < MSG_LEN; i++) if (mem[SRC+i] !== PAD) bad++;
      check("strip_tail_mismatches", bad, 0);
    end

    set_cfg(8'd9, 8'hd4, 8'h00);
    run(1'b0, 1'b0, 4, 1'b1, "seed0", -1);
    check("seed0_writes", wr_count, 0);
    set_cfg(8'd30, 8'hd4, 8'h41);
    run(1'b1, 1'b0, 4, 1'b1, "pre30", -1);
    check("pre30_writes", wr_count, 0);

    set_orig("Mr. Watson, come here. I want to see you.");
    load_orig();
    set_cfg(8'd9, 8'hd4, 8'h41);
    fill_region(DST, FRAME_LEN, 8'h00);
    push_enc();
    wr_count = 0;
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_addr == 8'(SRC + 11) && !mem_we) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", n < 500, 1);
    check("abort_writes", wr_count, 20);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_we", mem_we, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_wdata", mem_wdata, 0);
    sb.delete();
    we_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    check("abort_quiet", we_seen, 0);
    fill_region(DST, FRAME_LEN, 8'h00);
    push_enc();
    run(1'b0, 1'b0, 109, 1'b0, "rerun", -1);
    check_frame("rerun");

    for (int i = 0; i < 8; i++) begin
      set_cfg(8'(i * 3), taps_list[i], 8'(8'h1d + i * 37));
      push_enc();
      run(1'b0, 1'b0, 109, 1'b0, $sformatf("tap%0d", i),
          (i == 0) ? 20 : -1);
      check_frame($sformatf("tap%0d", i));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
